rr_mux_arbiter8x8: RTL and testbench

RR_MUX_ARBITER8X8 -- requirements
Module: rr_mux_arbiter8x8

---
 rtl/rr_mux_arbiter8x8.sv | 101 ++++++++++
 tb/tb_rr_mux_arbiter8x8.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter8x8.sv
// rr_mux_arbiter8x8: eight 8-bit requesters share one registered output.
// A round-robin arbiter picks a requester while idle and holds that grant
// for a whole packet (until a word with LAST is transferred). The output
// stage is a single register slice with a valid/ready handshake.
module rr_mux_arbiter8x8 (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [7:0] I3,
  input  logic [7:0] I4,
  input  logic [7:0] I5,
  input  logic [7:0] I6,
  input  logic [7:0] I7,
  input  logic [7:0] REQ_VALID,
  input  logic [7:0] REQ_LAST,
  output logic [7:0] REQ_READY,
  output logic [7:0] O,
  output logic       O_VALID,
  output logic       O_LAST,
  input  logic       O_READY,
  output logic [2:0] SEL,
  output logic       BUSY
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [2:0] ptr;         // index of the requester served last
  logic [2:0] pick;        // round-robin winner for the current REQ_VALID
  logic [7:0] din [8];
  logic       space;
  logic       xfer;

  assign din[0] = I0;
  assign din[1] = I1;
  assign din[2] = I2;
  assign din[3] = I3;
  assign din[4] = I4;
  assign din[5] = I5;
  assign din[6] = I6;
  assign din[7] = I7;

  // The output slice can take a word when it is empty or being drained.
  assign space     = !O_VALID || O_READY;
  assign xfer      = (state == GRANT) && REQ_VALID[SEL] && space;
  assign REQ_READY = xfer ? (8'b1 << SEL) : 8'b0;
  assign BUSY      = (state == GRANT);

  // Round-robin scan: ptr+1, ptr+2, ..., ptr+8 (== ptr itself, scanned last).
  always_comb begin
    // NOTE: pick gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    pick = ptr;
    for (int i = 8; i >= 1; i--) begin
      if (REQ_VALID[ptr + 3'(i)]) begin
        pick = ptr + 3'(i);
      end
    end
  end

  // Arbitration FSM: grab a winner in IDLE, release after the LAST word.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    // NOTE: every register here and below is reset (there is no memory
    // array), and all state updates use non-blocking assignments so the
    // reads in this block see pre-edge values regardless of process order.
    if (!ASYNCRESETN) begin
      state <= IDLE;
      ptr   <= 3'd7;
      SEL   <= 3'd0;
    end else if (state == IDLE) begin
      if (|REQ_VALID) begin
        SEL   <= pick;
        state <= GRANT;
      end
    end else begin
      if (xfer && REQ_LAST[SEL]) begin
        state <= IDLE;
        ptr   <= SEL;
      end
    end
  end

  // Output register slice: load on transfer, drop valid once drained.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O       <= 8'h00;
      O_LAST  <= 1'b0;
      O_VALID <= 1'b0;
    end else if (xfer) begin
      O       <= din[SEL];
      O_LAST  <= REQ_LAST[SEL];
      O_VALID <= 1'b1;
    end else if (O_READY) begin
      O_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter8x8.sv
// Self-checking bench for rr_mux_arbiter8x8. Each requester is fed from a
// source queue; every word is also pushed to that requester's expected
// queue and popped when it appears on the output. Data words carry the
// requester index in bits [7:5] so the scoreboard can route them.
module tb_rr_mux_arbiter8x8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } word_t;

  logic       CLK;
  logic       ASYNCRESETN;
  logic [7:0] in_w [8];
  logic [7:0] REQ_VALID;
  logic [7:0] REQ_LAST;
  logic [7:0] REQ_READY;
  logic [7:0] O;
  logic       O_VALID;
  logic       O_LAST;
  logic       O_READY;
  logic [2:0] SEL;
  logic       BUSY;

  rr_mux_arbiter8x8 dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .I0          (in_w[0]),
    .I1          (in_w[1]),
    .I2          (in_w[2]),
    .I3          (in_w[3]),
    .I4          (in_w[4]),
    .I5          (in_w[5]),
    .I6          (in_w[6]),
    .I7          (in_w[7]),
    .REQ_VALID   (REQ_VALID),
    .REQ_LAST    (REQ_LAST),
    .REQ_READY   (REQ_READY),
    .O           (O),
    .O_VALID     (O_VALID),
    .O_LAST      (O_LAST),
    .O_READY     (O_READY),
    .SEL         (SEL),
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  word_t      src_q [8][$];
  word_t      exp_q [8][$];
  logic [4:0] seq [8];
  logic [7:0] en;
  logic       o_ready_drv;
  int         order [$];
  int         hs_cyc [$];
  logic       in_pkt;
  logic [2:0] owner;
  int         cons_cnt [8];
  int         out_cnt [8];
  logic       rst_armed;
  int         rst_req;
  int         rst_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int n = 0; n < 8; n++) s += src_q[n].size() + exp_q[n].size();
    return s;
  endfunction

  task automatic enq(input int n, input int len);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.data = {3'(n), seq[n]};
      w.last = (i == len - 1);
      seq[n] = seq[n] + 5'd1;
      src_q[n].push_back(w);
      exp_q[n].push_back(w);
    end
  endtask

  task automatic drive_inputs();
    logic [7:0] v;
    logic [7:0] l;
    v = 8'h00;
    l = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (en[n] && src_q[n].size() != 0) begin
        v[n]    = 1'b1;
        l[n]    = src_q[n][0].last;
        in_w[n] = src_q[n][0].data;
      end else begin
        in_w[n] = 8'h00;
      end
    end
    REQ_VALID = v;
    REQ_LAST  = l;
    O_READY   = o_ready_drv;
  endtask

  // Evaluate what the coming rising edge will do, from settled signals.
  task automatic observe();
    int         n;
    word_t      w;
    logic [2:0] id;
    if (O_VALID === 1'b1 && o_ready_drv === 1'b1) begin
      id = O[7:5];
      check("sb_pending", 32'(exp_q[id].size() != 0), 1);
      if (exp_q[id].size() != 0) begin
        w = exp_q[id].pop_front();
        check("sb_data", O, w.data);
        check("sb_last", O_LAST, w.last);
      end
      if (in_pkt) check("sb_no_interleave", id, owner);
      else order.push_back(int'(id));
      in_pkt = !O_LAST;
      owner  = id;
      hs_cyc.push_back(cyc);
      out_cnt[id]++;
    end
    if (REQ_READY !== 8'h00) begin
      n = -1;
      for (int i = 7; i >= 0; i--) if (REQ_READY[i] === 1'b1) n = i;
      if (n < 0) begin
        check("rdy_known", REQ_READY, 0);
        return;
      end
      if (rst_armed && n == rst_req && cons_cnt[n] == rst_base + 1) begin
        // Reset pulse between edges while the second word is offered.
        ASYNCRESETN = 1'b0;
        #1;
        check("rst_mid_o", O, 0);
        check("rst_mid_ovalid", O_VALID, 0);
        check("rst_mid_olast", O_LAST, 0);
        check("rst_mid_ready", REQ_READY, 0);
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_sel", SEL, 0);
        #1;
        ASYNCRESETN = 1'b1;
        src_q[n].delete();
        exp_q[n].delete();
        in_pkt    = 1'b0;
        rst_armed = 1'b0;
        order.delete();
        drive_inputs();
        return;
      end
      check("rdy_onehot", REQ_READY, 8'h01 << n);
      check("rdy_sel", SEL, n);
      check("rdy_valid", REQ_VALID[n], 1);
      if (src_q[n].size() != 0) begin
        void'(src_q[n].pop_front());
        cons_cnt[n]++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    cyc++;
    drive_inputs();
    #1;
    observe();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int k = 0;
    while (pending() != 0 && k < max_cyc) begin
      cycle();
      k++;
    end
    check({tag, "_drain"}, pending(), 0);
    repeat (2) cycle();
    check({tag, "_idle_ovalid"}, O_VALID, 0);
    check({tag, "_idle_busy"}, BUSY, 0);
  endtask

  task automatic new_test();
    order.delete();
    hs_cyc.delete();
    in_pkt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    int k;

    for (int n = 0; n < 8; n++) begin
      seq[n]      = 5'd0;
      in_w[n]     = 8'h00;
      cons_cnt[n] = 0;
      out_cnt[n]  = 0;
    end
    en          = 8'hFF;
    o_ready_drv = 1'b1;
    in_pkt      = 1'b0;
    owner       = 3'd0;
    rst_armed   = 1'b0;
    rst_req     = 0;
    rst_base    = 0;
    REQ_VALID   = 8'hFF;
    REQ_LAST    = 8'hFF;
    O_READY     = 1'b1;

    // Reset: outputs forced at once, and held across a clock edge.
    ASYNCRESETN = 1'b1;
    #1 ASYNCRESETN = 1'b0;
    #2;
    check("rst_o", O, 0);
    check("rst_ovalid", O_VALID, 0);
    check("rst_olast", O_LAST, 0);
    check("rst_ready", REQ_READY, 0);
    check("rst_sel", SEL, 0);
    check("rst_busy", BUSY, 0);
    @(negedge CLK);
    #1;
    check("rst_hold_ready", REQ_READY, 0);
    check("rst_hold_busy", BUSY, 0);
    check("rst_hold_sel", SEL, 0);
    REQ_VALID = 8'h00;
    REQ_LAST  = 8'h00;
    ASYNCRESETN = 1'b1;

    // Requesters 0 and 7, single words: 0 first, then 7; 2-cycle latency.
    new_test();
    t0 = cyc + 1;
    enq(0, 1);
    enq(7, 1);
    drain("t2", 40);
    check("t2_count", order.size(), 2);
    check("t2_first", order[0], 0);
    check("t2_second", order[1], 7);
    check("t2_latency", hs_cyc[0] - t0, 2);

    // All eight valid: strict rotation 0..7 then 0 again.
    new_test();
    enq(0, 1);
    for (int n = 1; n < 8; n++) enq(n, 1);
    enq(0, 1);
    drain("t3", 100);
    check("t3_count", order.size(), 9);
    for (int i = 0; i < 9; i++) check("t3_order", order[i], i % 8);

    // 4-word packet from 3 with 5 waiting: contiguous, then one idle gap.
    new_test();
    enq(3, 4);
    enq(5, 1);
    drain("t4", 60);
    check("t4_count", order.size(), 2);
    check("t4_first", order[0], 3);
    check("t4_second", order[1], 5);
    check("t4_hs_count", hs_cyc.size(), 5);
    for (int i = 1; i < 4; i++) check("t4_back_to_back", hs_cyc[i] - hs_cyc[i-1], 1);
    check("t4_pkt_gap", hs_cyc[4] - hs_cyc[3], 2);

    // Downstream stall of 5 cycles inside a 6-word packet from 2.
    new_test();
    base = out_cnt[2];
    enq(2, 6);
    k = 0;
    while (out_cnt[2] < base + 2 && k < 40) begin
      cycle();
      k++;
    end
    check("t5_reach", 32'(out_cnt[2] >= base + 2), 1);
    o_ready_drv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_stall_ovalid", O_VALID, 1);
      check("t5_stall_o", O, (exp_q[2].size() != 0) ? exp_q[2][0].data : 8'hxx);
      check("t5_stall_ready", REQ_READY, 0);
    end
    o_ready_drv = 1'b1;
    drain("t5", 60);
    check("t5_words", out_cnt[2] - base, 6);
    check("t5_order", order[0], 2);

    // Reset pulse during the word-2 offer of a packet from 4.
    new_test();
    rst_req  = 4;
    rst_base = cons_cnt[4];
    rst_armed = 1'b1;
    enq(4, 4);
    enq(1, 1);
    enq(6, 1);
    k = 0;
    while (rst_armed && k < 60) begin
      cycle();
      k++;
    end
    check("t6_reset_hit", rst_armed, 0);
    drain("t6", 60);
    check("t6_count", order.size(), 2);
    check("t6_first", order[0], 1);
    check("t6_second", order[1], 6);

    // Only the last-served requester (6) valid: still granted.
    new_test();
    enq(6, 1);
    drain("t7", 30);
    check("t7_count", order.size(), 1);
    check("t7_first", order[0], 6);

    // Requester 0 drops valid mid-packet: stall, grant kept, 1 waits.
    new_test();
    base = cons_cnt[0];
    enq(0, 3);
    enq(1, 1);
    k = 0;
    while (cons_cnt[0] < base + 1 && k < 30) begin
      cycle();
      k++;
    end
    check("t8_reach", 32'(cons_cnt[0] >= base + 1), 1);
    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t8_gap_ready", REQ_READY, 0);
      check("t8_gap_sel", SEL, 0);
      check("t8_gap_busy", BUSY, 1);
    end
    en[0] = 1'b1;
    drain("t8", 60);
    check("t8_count", order.size(), 2);
    check("t8_first", order[0], 0);
    check("t8_second", order[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
